// File: rtl/svc_axi_pkg.sv
// svc_axi_pkg: AXI burst and response encodings shared by the AXI slave blocks,
// plus the state type of the read responder.
package svc_axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    RD_IDLE  = 1'b0,
    RD_BURST = 1'b1
  } rd_state_e;

  // Only 2, 4, 8 and 16 beat wrapping bursts are legal on AXI.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/svc_axi_burst_addr.sv
// svc_axi_burst_addr: combinational AXI beat-address stepper and 4 KB page check.
// WRAP stepping exists only when SVC_AXI_RD_RESP_WRAP_EN is defined; otherwise a
// WRAP burst simply holds its address (the caller flags it as an error).
module svc_axi_burst_addr
  import svc_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic [AXI_ADDR_WIDTH-1:0] addr,
  input  logic [2:0]                size,
  input  logic [7:0]                len,
  input  logic [1:0]                burst,
  output logic [AXI_ADDR_WIDTH-1:0] next_addr,
  output logic                      cross_4k
);

  localparam logic [AXI_ADDR_WIDTH-1:0] ONE = AXI_ADDR_WIDTH'(1);

  logic [AXI_ADDR_WIDTH-1:0] beat_bytes;
  logic [AXI_ADDR_WIDTH-1:0] aligned;
  logic [AXI_ADDR_WIDTH-1:0] incr_addr;
  logic [19:0]               burst_bytes;
  logic [19:0]               burst_end;
`ifdef SVC_AXI_RD_RESP_WRAP_EN
  logic [AXI_ADDR_WIDTH-1:0] wrap_mask;
`endif

  // Step the address by one beat and measure the whole burst against its 4 KB page.
  always_comb begin
    beat_bytes  = ONE << size;
    aligned     = addr & ~(beat_bytes - ONE);
    incr_addr   = aligned + beat_bytes;
    burst_bytes = (20'(len) + 20'd1) << size;
    burst_end   = 20'(12'(aligned)) + burst_bytes;
    cross_4k    = (burst == BURST_INCR) && (burst_end > 20'h01000);
`ifdef SVC_AXI_RD_RESP_WRAP_EN
    wrap_mask   = AXI_ADDR_WIDTH'(burst_bytes) - ONE;
`endif
    next_addr   = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
`ifdef SVC_AXI_RD_RESP_WRAP_EN
      BURST_WRAP: next_addr = (aligned & ~wrap_mask) | (incr_addr & wrap_mask);
`endif
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/svc_axi_rd_resp.sv
// svc_axi_rd_resp: AXI read-response slave in front of a 1-cycle-latency BRAM.
// One burst at a time; reads are issued ahead into a 2-entry skid buffer so full
// throughput survives backpressure. Define SVC_AXI_RD_RESP_WRAP_EN to support
// WRAP bursts; without it WRAP is answered with SLVERR.
module svc_axi_rd_resp
  import svc_axi_pkg::*;
#(
  parameter  int AXI_ADDR_WIDTH = 16,
  parameter  int AXI_DATA_WIDTH = 128,
  parameter  int AXI_ID_WIDTH   = 4,
  localparam int LANE_BITS      = $clog2(AXI_DATA_WIDTH / 8),
  localparam int MEM_AW         = AXI_ADDR_WIDTH - LANE_BITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic [2:0]                s_axi_arsize,
  input  logic [1:0]                s_axi_arburst,
  output logic                      s_axi_rvalid,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  input  logic                      s_axi_rready,
  output logic                      mem_ren,
  output logic [MEM_AW-1:0]         mem_raddr,
  input  logic [AXI_DATA_WIDTH-1:0] mem_rdata
);

  rd_state_e state, state_next;
  logic      init_done;

  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic [AXI_ADDR_WIDTH-1:0] beat_addr;
  logic [7:0]                len_q;
  logic [2:0]                size_q;
  logic [1:0]                burst_q;
  logic                      err_q;
  logic [8:0]                issue_left;

  logic                      pend_valid;
  logic                      pend_last;
  logic [AXI_DATA_WIDTH-1:0] skid_data [2];
  logic [1:0]                skid_last;
  logic [1:0]                skid_cnt;

  logic                      ar_hs;
  logic                      ar_err;
  logic                      r_pop;
  logic                      skid_has;
  logic                      skid_pop;
  logic                      push;
  logic                      push_idx;
  logic [2:0]                occupancy;
  logic                      issue;
  logic [AXI_DATA_WIDTH-1:0] in_data;

  logic [AXI_ADDR_WIDTH-1:0] ba_addr;
  logic [2:0]                ba_size;
  logic [7:0]                ba_len;
  logic [1:0]                ba_burst;
  logic [AXI_ADDR_WIDTH-1:0] next_addr;
  logic                      cross_4k;

  // The stepper sees the AR request while idle (page check) and the live burst otherwise.
  assign ba_addr  = (state == RD_IDLE) ? s_axi_araddr  : beat_addr;
  assign ba_size  = (state == RD_IDLE) ? s_axi_arsize  : size_q;
  assign ba_len   = (state == RD_IDLE) ? s_axi_arlen   : len_q;
  assign ba_burst = (state == RD_IDLE) ? s_axi_arburst : burst_q;

  svc_axi_burst_addr #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_burst_addr (
    .addr     (ba_addr),
    .size     (ba_size),
    .len      (ba_len),
    .burst    (ba_burst),
    .next_addr(next_addr),
    .cross_4k (cross_4k)
  );

  // Classify the incoming request; an error burst is still answered beat by beat.
  always_comb begin
    ar_err = 1'b0;
    if (s_axi_arburst == BURST_RSVD) ar_err = 1'b1;
    if (s_axi_arsize > 3'(LANE_BITS)) ar_err = 1'b1;
`ifdef SVC_AXI_RD_RESP_WRAP_EN
    if ((s_axi_arburst == BURST_WRAP) && !wrap_len_ok(s_axi_arlen)) ar_err = 1'b1;
`else
    if (s_axi_arburst == BURST_WRAP) ar_err = 1'b1;
`endif
    if (cross_4k) ar_err = 1'b1;
  end

  // Next-state and AR ready: accept a request only when idle and out of reset.
  always_comb begin
    state_next    = state;
    s_axi_arready = 1'b0;
    case (state)
      RD_IDLE: begin
        s_axi_arready = init_done;
        if (s_axi_arvalid && init_done) state_next = RD_BURST;
      end
      RD_BURST: begin
        if (r_pop && s_axi_rlast) state_next = RD_IDLE;
      end
      default: state_next = RD_IDLE;
    endcase
  end

  assign ar_hs = s_axi_arvalid && s_axi_arready;

  // The head of the skid buffer is older than the read in flight, so it is shown first.
  assign skid_has     = (skid_cnt != 2'd0);
  assign in_data      = err_q ? '0 : mem_rdata;
  assign s_axi_rvalid = skid_has || pend_valid;
  assign s_axi_rdata  = skid_has ? skid_data[0] : in_data;
  assign s_axi_rlast  = skid_has ? skid_last[0] : (pend_valid && pend_last);
  assign s_axi_rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rid    = id_q;

  assign r_pop     = s_axi_rvalid && s_axi_rready;
  assign skid_pop  = r_pop && skid_has;
  assign push      = pend_valid && !(r_pop && !skid_has);
  assign push_idx  = (skid_cnt == 2'd2) || ((skid_cnt == 2'd1) && !skid_pop);
  assign occupancy = {1'b0, skid_cnt} + {2'b00, pend_valid} - {2'b00, r_pop};
  assign issue     = (state == RD_BURST) && (issue_left != 9'd0) && (occupancy < 3'd2);
  assign mem_ren   = issue && !err_q;
  assign mem_raddr = MEM_AW'(beat_addr >> LANE_BITS);

  // State register; arready stays low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RD_IDLE;
      init_done <= 1'b0;
    end else begin
      state     <= state_next;
      init_done <= 1'b1;
    end
  end

  // Burst context: latched on AR handshake, address and beat count advance per issued read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q       <= '0;
      beat_addr  <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      err_q      <= 1'b0;
      issue_left <= '0;
    end else if (ar_hs) begin
      id_q       <= s_axi_arid;
      beat_addr  <= s_axi_araddr;
      len_q      <= s_axi_arlen;
      size_q     <= s_axi_arsize;
      burst_q    <= s_axi_arburst;
      err_q      <= ar_err;
      issue_left <= {1'b0, s_axi_arlen} + 9'd1;
    end else if (issue) begin
      beat_addr  <= next_addr;
      issue_left <= issue_left - 9'd1;
    end
  end

  // Read-in-flight flag and skid buffer occupancy/last flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      skid_cnt   <= 2'd0;
      skid_last  <= 2'b00;
    end else begin
      pend_valid <= issue;
      if (issue) pend_last <= (issue_left == 9'd1);
      if (skid_pop) skid_last[0] <= skid_last[1];
      if (push) skid_last[push_idx] <= pend_last;
      skid_cnt <= skid_cnt + {1'b0, push} - {1'b0, skid_pop};
    end
  end

  // Skid data storage; only meaningful where the occupancy count says so.
  always_ff @(posedge clk) begin
    if (skid_pop) skid_data[0] <= skid_data[1];
    if (push) skid_data[push_idx] <= in_data;
  end

endmodule

// File: tb/tb_svc_axi_rd_resp.sv
// tb_svc_axi_rd_resp: directed self-checking bench for svc_axi_rd_resp (DW=128).
// Honours SVC_AXI_RD_RESP_WRAP_EN the same way as the design.
module tb_svc_axi_rd_resp;
  import svc_axi_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_axi_arvalid;
  logic         s_axi_arready;
  logic [3:0]   s_axi_arid;
  logic [15:0]  s_axi_araddr;
  logic [7:0]   s_axi_arlen;
  logic [2:0]   s_axi_arsize;
  logic [1:0]   s_axi_arburst;
  logic         s_axi_rvalid;
  logic [3:0]   s_axi_rid;
  logic [127:0] s_axi_rdata;
  logic [1:0]   s_axi_rresp;
  logic         s_axi_rlast;
  logic         s_axi_rready;
  logic         mem_ren;
  logic [11:0]  mem_raddr;
  logic [127:0] mem_rdata = '0;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_cycle = 0;
  logic [11:0] ren_log [$];
  logic [11:0] exp_words [16];

  svc_axi_rd_resp dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_arid   (s_axi_arid),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arlen  (s_axi_arlen),
    .s_axi_arsize (s_axi_arsize),
    .s_axi_arburst(s_axi_arburst),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rid    (s_axi_rid),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rlast  (s_axi_rlast),
    .s_axi_rready (s_axi_rready),
    .mem_ren      (mem_ren),
    .mem_raddr    (mem_raddr),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Word contents are a fixed function of the word index so every beat is recognisable.
  function automatic logic [127:0] mem_word(input logic [11:0] w);
    return {w, 20'hA5A5A, w, 20'h5A5A5, w, 20'h12345, w, 20'hFEDCB};
  endfunction

  // Cycle counter, 1-cycle BRAM model and log of issued read addresses.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_ren) begin
      mem_rdata <= mem_word(mem_raddr);
      ren_log.push_back(mem_raddr);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Present an AR request from a negedge and wait (bounded) for its handshake.
  task automatic applyStimulus(input logic [3:0] id, input logic [15:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    bit done;
    done          = 1'b0;
    s_axi_arid    = id;
    s_axi_araddr  = addr;
    s_axi_arlen   = len;
    s_axi_arsize  = size;
    s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (s_axi_arready) begin
        hs_cycle = cyc;
        done     = 1'b1;
      end
      @(negedge clk);
    end
    s_axi_arvalid = 1'b0;
    if (!done) checkOutput("ar_handshake_timeout", 128'(done), 128'(1));
  endtask

  // Collect up to stop_after beats of an nbeats burst, checking every beat and stall.
  task automatic collectBurst(input int nbeats, input int stop_after, input bit exp_err,
                              input logic [3:0] exp_id, input int first_cyc, input bit toggle);
    int           beat;
    int           phase;
    bit           stalled;
    bit           seen;
    logic [127:0] held_data;
    logic         held_last;
    beat      = 0;
    phase     = 0;
    stalled   = 1'b0;
    seen      = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    while (beat < stop_after && phase < 300) begin
      s_axi_rready = toggle ? ((phase % 3) == 0) : 1'b1;
      phase++;
      if (stalled) begin
        checkOutput("stall_valid", 128'(s_axi_rvalid), 128'(1));
        checkOutput("stall_data", s_axi_rdata, held_data);
        checkOutput("stall_last", 128'(s_axi_rlast), 128'(held_last));
        stalled = 1'b0;
      end
      if (s_axi_rvalid) begin
        if (!seen && first_cyc >= 0)
          checkOutput("first_beat_cycle", 128'(cyc), 128'(first_cyc));
        seen = 1'b1;
        if (s_axi_rready) begin
          checkOutput("beat_data", s_axi_rdata, exp_err ? 128'(0) : mem_word(exp_words[beat]));
          checkOutput("beat_resp", 128'(s_axi_rresp), exp_err ? 128'(2) : 128'(0));
          checkOutput("beat_id", 128'(s_axi_rid), 128'(exp_id));
          checkOutput("beat_last", 128'(s_axi_rlast), 128'(beat == nbeats - 1));
          beat++;
        end else begin
          stalled   = 1'b1;
          held_data = s_axi_rdata;
          held_last = s_axi_rlast;
        end
      end
      @(negedge clk);
    end
    checkOutput("beat_count", 128'(beat), 128'(stop_after));
    if (stop_after == nbeats) begin
      checkOutput("no_extra_beat", 128'(s_axi_rvalid), 128'(0));
      checkOutput("arready_after_last", 128'(s_axi_arready), 128'(1));
    end
  endtask

  initial begin
    int stale;
    int t;
    rst_n         = 1'b0;
    s_axi_arvalid = 1'b0;
    s_axi_arid    = '0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    s_axi_arsize  = '0;
    s_axi_arburst = '0;
    s_axi_rready  = 1'b1;
    foreach (exp_words[i]) exp_words[i] = '0;

    // Reset values, then arready rises on the first edge after release.
    repeat (3) @(negedge clk);
    checkOutput("reset_arready", 128'(s_axi_arready), 128'(0));
    checkOutput("reset_rvalid", 128'(s_axi_rvalid), 128'(0));
    checkOutput("reset_rlast", 128'(s_axi_rlast), 128'(0));
    checkOutput("reset_mem_ren", 128'(mem_ren), 128'(0));
    rst_n = 1'b1;
    #1;
    checkOutput("arready_before_edge", 128'(s_axi_arready), 128'(0));
    @(negedge clk);
    checkOutput("arready_after_release", 128'(s_axi_arready), 128'(1));

    // INCR 0x0100, 4 beats of 16 B: words 0x10..0x13 from cycle N+2.
    $display("[TB] INCR burst");
    exp_words[0] = 12'h010; exp_words[1] = 12'h011;
    exp_words[2] = 12'h012; exp_words[3] = 12'h013;
    ren_log.delete();
    applyStimulus(4'h3, 16'h0100, 8'd3, 3'd4, 2'b01);
    collectBurst(4, 4, 1'b0, 4'h3, hs_cycle + 2, 1'b0);
    checkOutput("incr_ren_count", 128'(ren_log.size()), 128'(4));
    for (int i = 0; i < 4 && i < ren_log.size(); i++)
      checkOutput("incr_raddr", 128'(ren_log[i]), 128'(exp_words[i]));

    // WRAP 0x0120, 4 beats: words 0x12,0x13,0x10,0x11 (SLVERR when wrap is not built).
    $display("[TB] WRAP burst");
    exp_words[0] = 12'h012; exp_words[1] = 12'h013;
    exp_words[2] = 12'h010; exp_words[3] = 12'h011;
    ren_log.delete();
    applyStimulus(4'h4, 16'h0120, 8'd3, 3'd4, 2'b10);
`ifdef SVC_AXI_RD_RESP_WRAP_EN
    collectBurst(4, 4, 1'b0, 4'h4, hs_cycle + 2, 1'b0);
    checkOutput("wrap_ren_count", 128'(ren_log.size()), 128'(4));
`else
    collectBurst(4, 4, 1'b1, 4'h4, hs_cycle + 2, 1'b0);
    checkOutput("wrap_off_no_ren", 128'(ren_log.size()), 128'(0));
`endif

    // Backpressure: INCR 0x0200, 8 beats, rready 1,0,0 repeating.
    $display("[TB] backpressure burst");
    for (int i = 0; i < 8; i++) exp_words[i] = 12'h020 + 12'(i);
    ren_log.delete();
    applyStimulus(4'h6, 16'h0200, 8'd7, 3'd4, 2'b01);
    collectBurst(8, 8, 1'b0, 4'h6, -1, 1'b1);
    checkOutput("bp_ren_count", 128'(ren_log.size()), 128'(8));

    // Error bursts: reserved burst type, 4 KB crossing, oversize beat.
    $display("[TB] error bursts");
    ren_log.delete();
    applyStimulus(4'h7, 16'h0300, 8'd1, 3'd4, 2'b11);
    collectBurst(2, 2, 1'b1, 4'h7, hs_cycle + 2, 1'b0);
    checkOutput("rsvd_no_ren", 128'(ren_log.size()), 128'(0));
    applyStimulus(4'h8, 16'h0FF0, 8'd1, 3'd4, 2'b01);
    collectBurst(2, 2, 1'b1, 4'h8, hs_cycle + 2, 1'b0);
    checkOutput("cross4k_no_ren", 128'(ren_log.size()), 128'(0));
    applyStimulus(4'hA, 16'h0000, 8'd0, 3'd5, 2'b01);
    collectBurst(1, 1, 1'b1, 4'hA, hs_cycle + 2, 1'b0);
    checkOutput("oversize_no_ren", 128'(ren_log.size()), 128'(0));

    // Back-to-back: second AR held during the first burst, accepted right after rlast.
    $display("[TB] back-to-back bursts");
    exp_words[0] = 12'h040; exp_words[1] = 12'h041;
    applyStimulus(4'h5, 16'h0400, 8'd1, 3'd4, 2'b01);
    s_axi_arid    = 4'h9;
    s_axi_araddr  = 16'h0500;
    s_axi_arlen   = 8'd2;
    s_axi_arvalid = 1'b1;
    collectBurst(2, 2, 1'b0, 4'h5, hs_cycle + 2, 1'b0);
    t = cyc;
    exp_words[0] = 12'h050; exp_words[1] = 12'h051; exp_words[2] = 12'h052;
    applyStimulus(4'h9, 16'h0500, 8'd2, 3'd4, 2'b01);
    checkOutput("b2b_hs_cycle", 128'(hs_cycle), 128'(t));
    collectBurst(3, 3, 1'b0, 4'h9, hs_cycle + 2, 1'b0);

    // Reset after beat 2 of 8: outputs drop at once, no stale beats after release.
    $display("[TB] reset mid-burst");
    for (int i = 0; i < 8; i++) exp_words[i] = 12'h060 + 12'(i);
    applyStimulus(4'h2, 16'h0600, 8'd7, 3'd4, 2'b01);
    collectBurst(8, 2, 1'b0, 4'h2, hs_cycle + 2, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_rvalid", 128'(s_axi_rvalid), 128'(0));
    checkOutput("midrst_mem_ren", 128'(mem_ren), 128'(0));
    checkOutput("midrst_arready", 128'(s_axi_arready), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    s_axi_rready = 1'b1;
    @(negedge clk);
    checkOutput("midrst_arready_after", 128'(s_axi_arready), 128'(1));
    stale = 0;
    repeat (12) begin
      if (s_axi_rvalid) stale++;
      @(negedge clk);
    end
    checkOutput("midrst_no_stale", 128'(stale), 128'(0));

    // A single-beat burst still works after the mid-burst reset.
    exp_words[0] = 12'h001;
    applyStimulus(4'h1, 16'h0010, 8'd0, 3'd4, 2'b01);
    collectBurst(1, 1, 1'b0, 4'h1, hs_cycle + 2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/svc_axi_rd_resp.md
SVC_AXI_RD_RESP -- requirements
Module: svc_axi_rd_resp

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 16, meaning byte address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 128, meaning R data width.
REQ-003 SHALL have parameter AXI_ID_WIDTH, default 4, meaning ID width.
REQ-004 SHALL define MEM_AW as AXI_ADDR_WIDTH - log2(AXI_DATA_WIDTH/8), meaning word index width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have ports s_axi_arvalid/arready (1), arid (AXI_ID_WIDTH), araddr (AXI_ADDR_WIDTH), arlen (8), arsize (3), arburst (2): the AR channel, slave side; arready is an output.
REQ-008 SHALL have ports s_axi_rvalid (1), rid (AXI_ID_WIDTH), rdata (AXI_DATA_WIDTH), rresp (2), rlast (1), rready (1): the R channel, slave side; rready is an input.
REQ-009 SHALL have ports mem_ren (output, 1), mem_raddr (output, MEM_AW), mem_rdata (input, AXI_DATA_WIDTH): a BRAM read port with 1-cycle read latency.

Function
REQ-010 SHALL implement a two-state FSM:
- IDLE: arready=1.
- BURST: arready=0.
- IDLE->BURST on the AR handshake; arid, araddr, arlen, arsize and arburst are latched at that point.
- BURST->IDLE on the R handshake with rlast=1.
REQ-011 SHALL, for an AR handshake on cycle N, present the first beat with rvalid=1 on cycle N+2.
REQ-012 SHALL sustain one beat per cycle while rready=1, using a 2-entry output skid buffer so that no mem read result is lost under backpressure.
REQ-013 SHALL assert mem_ren only when a skid entry is free or is being freed in the same cycle.
REQ-014 SHALL hold rvalid, rdata, rid, rresp and rlast stable while rvalid=1 and rready=0.
REQ-015 SHALL return exactly arlen+1 beats, with rlast=1 on the final beat only, and rid equal to the latched arid on every beat.
REQ-016 SHALL advance the beat address as follows:
- FIXED (2'b00): address is constant.
- INCR (2'b01): address += 1<<arsize.
- WRAP (2'b10): address += 1<<arsize, wrapping within the aligned (arlen+1)*(1<<arsize)-byte window.
REQ-017 SHALL set mem_raddr to the beat address >> log2(AXI_DATA_WIDTH/8); sub-word lanes are returned unmodified.
REQ-018 SHALL flag a burst as an error when any of these holds:
- arburst=2'b11;
- arsize > log2(AXI_DATA_WIDTH/8);
- WRAP with arlen not in {1,3,7,15};
- INCR crosses a 4 KB boundary.
For an error burst it SHALL still return arlen+1 beats, with rresp=SLVERR (2'b10), rdata=0 and mem_ren=0; otherwise rresp=OKAY.
REQ-019 SHALL raise arready in the cycle after the last-beat handshake, allowing a new AR handshake there; it SHALL NOT overlap bursts.

Reset
REQ-020 SHALL, while rst_n=0, hold:
- FSM in IDLE;
- skid buffer empty;
- rvalid=0, rlast=0, mem_ren=0;
- arready=0.
arready SHALL become 1 on the first clock edge after reset is released.
REQ-021 SHALL, on reset asserted mid-burst, abandon the burst silently with no further beats after release.

Configuration
REQ-022 SHALL support macro SVC_AXI_RD_RESP_WRAP_EN:
- Defined: WRAP bursts behave per REQ-016.
- Undefined: arburst=2'b10 is treated as an error per REQ-018, and no wrap logic is synthesized.

Structure
REQ-023 SHALL take burst encodings (FIXED/INCR/WRAP) and resp codes (OKAY/SLVERR) from shared package svc_axi_pkg.
REQ-024 SHALL place next-address computation (REQ-016 and the 4 KB check) in sub-module svc_axi_burst_addr, which is combinational, with inputs addr, size, len and burst, and output next_addr.

Verification (DW=128, 16 B/beat)
REQ-025 SHALL cover an INCR read: araddr=0x0100, arlen=3, arsize=4, rready=1 -> mem_raddr 0x10,0x11,0x12,0x13; four beats on consecutive cycles starting at N+2; rlast on the 4th beat; rresp=OKAY.
REQ-026 SHALL cover a WRAP read (WRAP_EN defined): araddr=0x0120, arlen=3, arsize=4 -> word order 0x12,0x13,0x10,0x11.
REQ-027 SHALL cover backpressure: INCR arlen=7 with rready toggled 1,0,0,1,... -> all 8 beats delivered in order with stable data across stalls, none dropped or duplicated.
REQ-028 SHALL cover errors: arburst=2'b11, arlen=1 -> two beats, each with rresp=2'b10 and rdata=0, and mem_ren never asserted; an INCR burst at araddr=0x0FF0 with arlen=1 -> SLVERR.
REQ-029 SHALL cover back-to-back bursts: second arvalid held high during the first burst -> arready=1 in the cycle after the first rlast handshake; the second burst's rid equals its own arid.
REQ-030 SHALL cover reset mid-burst: rst_n=0 after beat 2 of 8 -> rvalid=0 immediately; after release, arready=1 and no stale beats appear.
